// File: rtl/eth_phy_10g_pkg.sv
// ============================================================================
// eth_phy_10g_pkg : shared sync-header constants, lock thresholds, lock states
// Revision: 1.0
// ============================================================================
`default_nettype none

package eth_phy_10g_pkg;

   localparam logic [1:0] SYNC_DATA = 2'b01;
   localparam logic [1:0] SYNC_CTRL = 2'b10;

   localparam int LOCK_HDR_COUNT   = 64;
   localparam int LOCK_INVALID_MAX = 16;
   localparam int BER_HIGH_THRESH  = 16;

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_LOCKED   = 2'd1,
      ST_SLIP     = 2'd2
   } lock_state_t;

   function automatic logic sync_hdr_ok(input logic [1:0] hdr);
      return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
   endfunction

endpackage

`default_nettype wire

// File: rtl/eth_phy_10g_rx_ber_mon.sv
// ============================================================================
// eth_phy_10g_rx_ber_mon : 125 us window invalid-header counter and high-BER flag
// Revision: 1.0
// ============================================================================
`default_nettype none

module eth_phy_10g_rx_ber_mon
   import eth_phy_10g_pkg::*;
#(
   parameter int COUNT_125US = 19531
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       hdr_valid,
   input  logic       hdr_invalid,
   output logic       rx_high_ber,
   output logic [5:0] rx_ber_count
);

   localparam logic [14:0] TIMER_LAST = 15'(COUNT_125US - 1);
   localparam logic [5:0]  BER_HIGH   = 6'(BER_HIGH_THRESH);

   logic [14:0] timer;
   logic [5:0]  ber_cnt;
   logic [5:0]  ber_cnt_sat;
   logic        err;

   assign err          = hdr_valid && hdr_invalid;
   assign ber_cnt_sat  = (ber_cnt == 6'd63) ? 6'd63 : ber_cnt + 6'd1;
   assign rx_ber_count = ber_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         timer       <= 15'd0;
         ber_cnt     <= 6'd0;
         rx_high_ber <= 1'b0;
      end else if (timer == TIMER_LAST) begin
         // Verdict uses the closing window; the wrap-cycle header opens the next one
         timer       <= 15'd0;
         rx_high_ber <= (ber_cnt >= BER_HIGH);
         ber_cnt     <= {5'd0, err};
      end else begin
         timer <= timer + 15'd1;
         if (err) begin
            ber_cnt <= ber_cnt_sat;
            if (ber_cnt_sat >= BER_HIGH) begin
               rx_high_ber <= 1'b1;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/eth_phy_10g_rx_link_mon.sv
// ============================================================================
// eth_phy_10g_rx_link_mon : 10GBASE-R block-lock FSM with gearbox bitslip and BER
// Revision: 1.0
// ============================================================================
`default_nettype none

module eth_phy_10g_rx_link_mon
   import eth_phy_10g_pkg::*;
#(
   parameter int HDR_WIDTH           = 2,
   parameter int BITSLIP_HIGH_CYCLES = 1,
   parameter int BITSLIP_LOW_CYCLES  = 8,
   parameter int COUNT_125US         = 19531
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [HDR_WIDTH-1:0] serdes_rx_hdr,
   output logic                 serdes_rx_bitslip,
   output logic                 rx_block_lock,
   output logic                 rx_high_ber,
   output logic                 rx_sh_error,
   output logic [5:0]           rx_ber_count
);

   localparam int SLIP_TOTAL = BITSLIP_HIGH_CYCLES + BITSLIP_LOW_CYCLES;
   localparam int SLIP_W     = $clog2(SLIP_TOTAL + 1);

   localparam logic [SLIP_W-1:0] SLIP_HIGH_END = SLIP_W'(BITSLIP_HIGH_CYCLES);
   localparam logic [SLIP_W-1:0] SLIP_END      = SLIP_W'(SLIP_TOTAL);
   localparam logic [6:0]        HDR_LIMIT     = 7'(LOCK_HDR_COUNT);
   localparam logic [4:0]        INVALID_LIMIT = 5'(LOCK_INVALID_MAX);

   lock_state_t       state;
   logic [6:0]        sh_cnt;
   logic [4:0]        sh_invalid_cnt;
   logic [SLIP_W-1:0] slip_cnt;

   logic              hdr_invalid;
   logic              evaluate;
   logic [6:0]        sh_cnt_inc;
   logic [4:0]        invalid_cnt_inc;
   logic [SLIP_W-1:0] slip_cnt_inc;

   assign hdr_invalid     = !sync_hdr_ok(serdes_rx_hdr[1:0]);
   assign evaluate        = (state != ST_SLIP);
   assign sh_cnt_inc      = sh_cnt + 7'd1;
   assign invalid_cnt_inc = sh_invalid_cnt + {4'd0, hdr_invalid};
   assign slip_cnt_inc    = slip_cnt + SLIP_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= ST_UNLOCKED;
         sh_cnt            <= 7'd0;
         sh_invalid_cnt    <= 5'd0;
         slip_cnt          <= '0;
         serdes_rx_bitslip <= 1'b0;
         rx_block_lock     <= 1'b0;
         rx_sh_error       <= 1'b0;
      end else begin
         rx_sh_error <= evaluate && hdr_invalid;
         case (state)
            ST_UNLOCKED: begin
               if (hdr_invalid) begin
                  state             <= ST_SLIP;
                  serdes_rx_bitslip <= 1'b1;
                  slip_cnt          <= '0;
                  sh_cnt            <= 7'd0;
                  sh_invalid_cnt    <= 5'd0;
               end else if (sh_cnt_inc == HDR_LIMIT && sh_invalid_cnt == 5'd0) begin
                  state          <= ST_LOCKED;
                  rx_block_lock  <= 1'b1;
                  sh_cnt         <= 7'd0;
                  sh_invalid_cnt <= 5'd0;
               end else begin
                  sh_cnt <= sh_cnt_inc;
               end
            end
            ST_LOCKED: begin
               // Losing lock wins over the end-of-window clear on the same header
               if (invalid_cnt_inc == INVALID_LIMIT) begin
                  state             <= ST_SLIP;
                  rx_block_lock     <= 1'b0;
                  serdes_rx_bitslip <= 1'b1;
                  slip_cnt          <= '0;
                  sh_cnt            <= 7'd0;
                  sh_invalid_cnt    <= 5'd0;
               end else if (sh_cnt_inc == HDR_LIMIT) begin
                  sh_cnt         <= 7'd0;
                  sh_invalid_cnt <= 5'd0;
               end else begin
                  sh_cnt         <= sh_cnt_inc;
                  sh_invalid_cnt <= invalid_cnt_inc;
               end
            end
            ST_SLIP: begin
               slip_cnt <= slip_cnt_inc;
               if (slip_cnt_inc == SLIP_HIGH_END) begin
                  serdes_rx_bitslip <= 1'b0;
               end
               if (slip_cnt_inc == SLIP_END) begin
                  state <= ST_UNLOCKED;
               end
            end
            default: begin
               state             <= ST_UNLOCKED;
               serdes_rx_bitslip <= 1'b0;
               rx_block_lock     <= 1'b0;
            end
         endcase
      end
   end

   eth_phy_10g_rx_ber_mon #(
      .COUNT_125US (COUNT_125US)
   ) u_ber_mon (
      .clk          (clk),
      .rst          (rst),
      .hdr_valid    (evaluate),
      .hdr_invalid  (hdr_invalid),
      .rx_high_ber  (rx_high_ber),
      .rx_ber_count (rx_ber_count)
   );

endmodule

`default_nettype wire
